// File: rtl/conv_pe_array.sv
// conv_pe_array: weight-stationary systolic MAC array, one signed dot product per output column per accepted vector.
// Latency: data_valid_in sampled at edge t -> psum_valid_out after edge t+REG_IN_CHANNEL_NUM; one vector per cycle.
// Backpressure: none; vectors are dropped while no complete weight set is active. Macro CONV_PE_WGT_DBUF_EN adds a shadow weight bank.
module conv_pe_array #(
  parameter int REG_IN_CHANNEL_NUM  = 9,
  parameter int REG_OUT_CHANNEL_NUM = 18,
  parameter int DATA_WIDTH_IN       = 8,
  parameter int WEIGHT_WIDTH        = 8,
  parameter int PSUM_WIDTH          = 24
) (
  input  logic                                                        clk,
  input  logic                                                        rstn,
  input  logic [REG_IN_CHANNEL_NUM*DATA_WIDTH_IN*REG_OUT_CHANNEL_NUM-1:0] data_in,
  input  logic                                                        data_valid_in,
  input  logic                                                        wgt_load_start,
  input  logic [WEIGHT_WIDTH*REG_OUT_CHANNEL_NUM-1:0]                 wgt_data_in,
  output logic                                                        wgt_load_busy,
  output logic                                                        wgt_ready,
  output logic [PSUM_WIDTH*REG_OUT_CHANNEL_NUM-1:0]                   psum_out,
  output logic                                                        psum_valid_out
);

  localparam int NI  = REG_IN_CHANNEL_NUM;
  localparam int NO  = REG_OUT_CHANNEL_NUM;
  localparam int PRW = DATA_WIDTH_IN + WEIGHT_WIDTH;
  localparam int CW  = (NI > 1) ? $clog2(NI) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NI - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SWAP_WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic          row_we;
  logic          start_ok;
  logic          accept;
  logic          pipe_empty;
  logic [NI:0]   vpipe_q;

  logic signed [WEIGHT_WIDTH-1:0] w_act_q [NO][NI];
`ifdef CONV_PE_WGT_DBUF_EN
  logic signed [WEIGHT_WIDTH-1:0] w_shd_q [NO][NI];
  logic                           bank_swap;
`endif
  logic signed [PRW-1:0]          prod_q  [NO][NI];
  logic signed [PSUM_WIDTH-1:0]   psum_q  [NO][NI];

  // The valid pipe has one extra stage for the product register in front of the adder chain.
  assign pipe_empty = (vpipe_q == '0);

`ifdef CONV_PE_WGT_DBUF_EN
  // Loads go to the shadow bank, so a start never has to wait for the stream to drain.
  assign start_ok = 1'b1;
  assign accept   = data_valid_in && ready_q && (state_q != ST_SWAP_WAIT);
`else
  // Single bank: a reload must not disturb vectors still walking down the columns.
  assign start_ok = pipe_empty && !data_valid_in;
  assign accept   = data_valid_in && ready_q && (state_q == ST_IDLE);
`endif

  // Load FSM next-state, row write enable and ready flag
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    row_we  = 1'b0;
`ifdef CONV_PE_WGT_DBUF_EN
    bank_swap = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (wgt_load_start && start_ok) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
`ifndef CONV_PE_WGT_DBUF_EN
          ready_d = 1'b0;
`endif
        end
      end
      ST_LOAD: begin
        row_we = 1'b1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
`ifdef CONV_PE_WGT_DBUF_EN
          state_d = ST_SWAP_WAIT;
`else
          state_d = ST_IDLE;
          ready_d = 1'b1;
`endif
        end
      end
      ST_SWAP_WAIT: begin
`ifdef CONV_PE_WGT_DBUF_EN
        if (pipe_empty && !data_valid_in) begin
          bank_swap = 1'b1;
          ready_d   = 1'b1;
          state_d   = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Load FSM state, row counter and ready flag registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Valid pipe tracks accepted vectors alongside the partial sums
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vpipe_q <= '0;
    end else begin
      vpipe_q <= {vpipe_q[NI-1:0], accept};
    end
  end

  // Weight banks: rows written one per cycle during LOAD
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int j = 0; j < NO; j++) begin
        for (int k = 0; k < NI; k++) begin
          w_act_q[j][k] <= '0;
`ifdef CONV_PE_WGT_DBUF_EN
          w_shd_q[j][k] <= '0;
`endif
        end
      end
    end else begin
`ifdef CONV_PE_WGT_DBUF_EN
      if (row_we) begin
        for (int j = 0; j < NO; j++) begin
          w_shd_q[j][cnt_q] <= wgt_data_in[j*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        end
      end
      if (bank_swap) begin
        w_act_q <= w_shd_q;
      end
`else
      if (row_we) begin
        for (int j = 0; j < NO; j++) begin
          w_act_q[j][cnt_q] <= wgt_data_in[j*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        end
      end
`endif
    end
  end

  // PE array: registered product then accumulate into the column chain; runs every cycle
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int j = 0; j < NO; j++) begin
        for (int k = 0; k < NI; k++) begin
          prod_q[j][k] <= '0;
          psum_q[j][k] <= '0;
        end
      end
    end else begin
      for (int j = 0; j < NO; j++) begin
        for (int k = 0; k < NI; k++) begin
          prod_q[j][k] <= PRW'($signed(data_in[(j*NI+k)*DATA_WIDTH_IN +: DATA_WIDTH_IN]))
                        * PRW'(w_act_q[j][k]);
        end
        psum_q[j][0] <= PSUM_WIDTH'(prod_q[j][0]);
        for (int k = 1; k < NI; k++) begin
          psum_q[j][k] <= psum_q[j][k-1] + PSUM_WIDTH'(prod_q[j][k]);
        end
      end
    end
  end

  // Column results come straight off the last PE of each chain
  always_comb begin
    psum_out = '0;
    for (int j = 0; j < NO; j++) begin
      psum_out[j*PSUM_WIDTH +: PSUM_WIDTH] = psum_q[j][NI-1];
    end
  end

  assign psum_valid_out = vpipe_q[NI];
  assign wgt_load_busy  = (state_q != ST_IDLE);
  assign wgt_ready      = ready_q;

endmodule

// File: tb/tb_conv_pe_array.sv
// tb_conv_pe_array: directed bench for conv_pe_array with an upstream skew model and a result scoreboard.
// Latency: each accepted vector is expected exactly REG_IN_CHANNEL_NUM cycles after it is driven.
// Backpressure: none; vectors the bench expects to be masked push nothing, so stray results are caught.
module tb_conv_pe_array;
  localparam int NI    = 9;
  localparam int NO    = 18;
  localparam int DW    = 8;
  localparam int WW    = 8;
  localparam int PW    = 24;
  localparam int DIN_W = NI*DW*NO;
  localparam int WR_W  = WW*NO;
  localparam int PO_W  = PW*NO;

  typedef struct {
    logic [PO_W-1:0] psum;
    int              cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [DIN_W-1:0]  data_in = '0;
  logic              data_valid_in = 1'b0;
  logic              wgt_load_start = 1'b0;
  logic [WR_W-1:0]   wgt_data_in = '0;
  logic              wgt_load_busy;
  logic              wgt_ready;
  logic [PO_W-1:0]   psum_out;
  logic              psum_valid_out;

  int                checks = 0;
  int                errors = 0;
  int                cyc = 0;
  int                Wm [NO][NI];
  int                Wn [NO][NI];
  logic [DIN_W-1:0]  hist [NI];
  exp_t              sb_q [$];
  exp_t              mon_e;

  always #5 clk = ~clk;

  // Cycle counter used for latency checks
  always @(posedge clk) cyc <= cyc + 1;

  conv_pe_array #(
    .REG_IN_CHANNEL_NUM (NI),
    .REG_OUT_CHANNEL_NUM(NO),
    .DATA_WIDTH_IN      (DW),
    .WEIGHT_WIDTH       (WW),
    .PSUM_WIDTH         (PW)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .data_in       (data_in),
    .data_valid_in (data_valid_in),
    .wgt_load_start(wgt_load_start),
    .wgt_data_in   (wgt_data_in),
    .wgt_load_busy (wgt_load_busy),
    .wgt_ready     (wgt_ready),
    .psum_out      (psum_out),
    .psum_valid_out(psum_valid_out)
  );

  // Result monitor: every valid result must match the oldest pending expectation
  always @(negedge clk) begin
    if (rstn && psum_valid_out) begin
      checks++;
      assert (sb_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_result observed=valid expected=no_pending_vector");
      end
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        checks++;
        assert (psum_out === mon_e.psum) else begin
          errors++;
          $error("FAIL psum observed=%0h expected=%0h", psum_out, mon_e.psum);
        end
        checks++;
        assert ((cyc - mon_e.cyc) === NI) else begin
          errors++;
          $error("FAIL latency observed=%0d expected=%0d", cyc - mon_e.cyc, NI);
        end
      end
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [PO_W-1:0] obs, input logic [PO_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DIN_W-1:0] fill_vec(input logic [7:0] x);
    logic [DIN_W-1:0] v;
    for (int b = 0; b < DIN_W/8; b++) v[b*8 +: 8] = x;
    return v;
  endfunction

  function automatic logic [DIN_W-1:0] rand_vec();
    logic [DIN_W-1:0] v;
    for (int b = 0; b < DIN_W/8; b++) v[b*8 +: 8] = 8'($urandom_range(0, 255));
    return v;
  endfunction

  function automatic logic [WR_W-1:0] wrow(input int k);
    logic [WR_W-1:0] r;
    for (int j = 0; j < NO; j++) r[j*WW +: WW] = 8'(Wn[j][k]);
    return r;
  endfunction

  // Reference dot product against the bench's view of the active weights
  function automatic logic [PO_W-1:0] ref_dot(input logic [DIN_W-1:0] v);
    logic [PO_W-1:0]  r;
    logic signed [7:0] b;
    logic [31:0]       su;
    int                s;
    r = '0;
    for (int j = 0; j < NO; j++) begin
      s = 0;
      for (int k = 0; k < NI; k++) begin
        b = v[(j*NI+k)*DW +: DW];
        s += int'(b) * Wm[j][k];
      end
      su = s;
      r[j*PW +: PW] = su[PW-1:0];
    end
    return r;
  endfunction

  task automatic set_wn_const(input int w);
    for (int j = 0; j < NO; j++)
      for (int k = 0; k < NI; k++) Wn[j][k] = w;
  endtask

  task automatic set_wn_rand();
    for (int j = 0; j < NO; j++)
      for (int k = 0; k < NI; k++) Wn[j][k] = int'($urandom_range(0, 255)) - 128;
  endtask

  // One clock of stimulus: byte k of each column comes from the vector issued k cycles ago
  task automatic step(input logic vld, input logic acc, input logic st,
                      input logic [WR_W-1:0] row, input logic [DIN_W-1:0] v);
    exp_t e;
    for (int k = NI-1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = v;
    for (int j = 0; j < NO; j++)
      for (int k = 0; k < NI; k++)
        data_in[(j*NI+k)*DW +: DW] = hist[k][(j*NI+k)*DW +: DW];
    data_valid_in  = vld;
    wgt_load_start = st;
    wgt_data_in    = row;
    @(posedge clk);
    #1;
    if (acc) begin
      e.psum = ref_dot(v);
      e.cyc  = cyc;
      sb_q.push_back(e);
    end
    data_valid_in  = 1'b0;
    wgt_load_start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, rand_vec());
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 30 && sb_q.size() != 0; i++) idle(1);
    chk1("drain", sb_q.size() == 0, 1'b1);
  endtask

  // Full weight load from Wn; Wm follows once the new bank is active
  task automatic do_load();
    step(1'b0, 1'b0, 1'b1, '0, rand_vec());
    chk1("load_busy_start", wgt_load_busy, 1'b1);
    for (int k = 0; k < NI; k++) begin
      step(1'b0, 1'b0, 1'b0, wrow(k), rand_vec());
`ifndef CONV_PE_WGT_DBUF_EN
      if (k == 3) chk1("load_ready_low", wgt_ready, 1'b0);
`endif
    end
`ifdef CONV_PE_WGT_DBUF_EN
    chk1("load_swap_wait", wgt_load_busy, 1'b1);
    idle(1);
`endif
    chk1("load_done_busy", wgt_load_busy, 1'b0);
    chk1("load_done_ready", wgt_ready, 1'b1);
    Wm = Wn;
  endtask

  initial begin
    for (int k = 0; k < NI; k++) hist[k] = '0;
    set_wn_const(0);
    Wm = Wn;

    // Reset with random inputs
    rstn = 1'b0;
    for (int i = 0; i < 3; i++)
      step(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), WR_W'($urandom), rand_vec());
    chkv("reset_psum", psum_out, '0);
    chk1("reset_valid", psum_valid_out, 1'b0);
    chk1("reset_busy", wgt_load_busy, 1'b0);
    chk1("reset_ready", wgt_ready, 1'b0);
    rstn = 1'b1;

    // Vectors without weights are masked
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, '0, rand_vec());
    chk1("masked_no_result", psum_valid_out, 1'b0);
    chk1("masked_ready", wgt_ready, 1'b0);

    // All weights 1, all bytes 2 -> 18 per column
    set_wn_const(1);
    do_load();
    step(1'b1, 1'b1, 1'b0, '0, fill_vec(8'd2));
    wait_drain();

    // Signed extremes
    set_wn_const(-128);
    do_load();
    step(1'b1, 1'b1, 1'b0, '0, fill_vec(8'h80));
    wait_drain();
    set_wn_const(127);
    do_load();
    step(1'b1, 1'b1, 1'b0, '0, fill_vec(8'h80));
    wait_drain();

    // Four back-to-back random vectors under random weights
    set_wn_rand();
    do_load();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, '0, rand_vec());
    wait_drain();

    // Load request while results are in flight
    set_wn_rand();
`ifdef CONV_PE_WGT_DBUF_EN
    step(1'b1, 1'b1, 1'b0, '0, rand_vec());
    step(1'b1, 1'b1, 1'b1, '0, rand_vec());
    chk1("dbuf_start_busy", wgt_load_busy, 1'b1);
    for (int k = 0; k < NI; k++) step(1'b1, 1'b1, 1'b0, wrow(k), rand_vec());
    chk1("dbuf_swap_wait", wgt_load_busy, 1'b1);
    step(1'b1, 1'b0, 1'b0, '0, rand_vec());
    chk1("dbuf_swap_hold", wgt_load_busy, 1'b1);
    for (int i = 0; i < 20 && wgt_load_busy; i++) idle(1);
    chk1("dbuf_swap_done", wgt_load_busy, 1'b0);
    chk1("dbuf_ready", wgt_ready, 1'b1);
    Wm = Wn;
    step(1'b1, 1'b1, 1'b0, '0, rand_vec());
    wait_drain();
`else
    step(1'b1, 1'b1, 1'b0, '0, rand_vec());
    step(1'b0, 1'b0, 1'b1, wrow(0), rand_vec());
    chk1("inflight_start_busy", wgt_load_busy, 1'b0);
    step(1'b1, 1'b1, 1'b1, wrow(0), rand_vec());
    chk1("valid_start_busy", wgt_load_busy, 1'b0);
    chk1("inflight_ready", wgt_ready, 1'b1);
    wait_drain();
    step(1'b1, 1'b1, 1'b0, '0, rand_vec());
    wait_drain();
`endif

    // Reset in the middle of a load, then a full reload
    set_wn_rand();
    step(1'b0, 1'b0, 1'b1, '0, rand_vec());
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, wrow(k), rand_vec());
    chk1("midload_busy", wgt_load_busy, 1'b1);
    rstn = 1'b0;
    step(1'b0, 1'b0, 1'b0, wrow(4), rand_vec());
    rstn = 1'b1;
    chk1("midload_reset_busy", wgt_load_busy, 1'b0);
    chk1("midload_reset_ready", wgt_ready, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, rand_vec());
    idle(10);
    chk1("midload_masked", psum_valid_out, 1'b0);
    set_wn_rand();
    do_load();
    step(1'b1, 1'b1, 1'b0, '0, rand_vec());
    step(1'b1, 1'b1, 1'b0, '0, rand_vec());
    wait_drain();

    chk1("scoreboard_empty", sb_q.size() == 0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
